// File: rtl/disp_pkg.sv
// Shared constants and hex-to-segment table for active-low 7-segment display blocks.
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low 7-segment pattern.
module hex7seg_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = hex2seg(nib);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame input snapshot,
// anti-ghosting blank at each digit switch and slow blink on selected digits.
module seg_scan_driver
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_TIME  = 50000,
  parameter int unsigned BLANK_TIME = 500,
  parameter int unsigned BLINK_TIME = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digit_val,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic [DIGITS-1:0]     dp_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned SCAN_W  = (SCAN_TIME  > 1) ? $clog2(SCAN_TIME)  : 1;
  localparam int unsigned IDX_W   = (DIGITS     > 1) ? $clog2(DIGITS)     : 1;
  localparam int unsigned BLINK_W = (BLINK_TIME > 1) ? $clog2(BLINK_TIME) : 1;

  logic [SCAN_W-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BLINK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [DIGITS-1:0][3:0]    val_s_q, val_s_d;
  logic [DIGITS-1:0]         en_s_q, en_s_d;
  logic [DIGITS-1:0]         blink_s_q, blink_s_d;
  logic [DIGITS-1:0]         dp_s_q, dp_s_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;

  logic [6:0] dec_seg;
  logic       frame_start;
  logic       visible;

  hex7seg_decode u_dec (
    .nib   (val_s_q[idx_q]),
    .seg_c (dec_seg)
  );

  always_comb begin
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    val_s_d       = val_s_q;
    en_s_d        = en_s_q;
    blink_s_d     = blink_s_q;
    dp_s_d        = dp_s_q;
    an_d          = {DIGITS{AN_OFF}};
    seg_d         = SEG_BLANK;
    dp_d          = DP_OFF;

    frame_start = (scan_cnt_q == '0) && (idx_q == '0);
    visible     = en_s_q[idx_q] && !(blink_s_q[idx_q] && blink_phase_q);

    // Slot timing and digit advance
    if (scan_cnt_q == SCAN_W'(SCAN_TIME - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (blink_cnt_q == BLINK_W'(BLINK_TIME - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Inputs only enter the display path at frame start to avoid tearing
    if (frame_start) begin
      val_s_d   = digit_val;
      en_s_d    = digit_en;
      blink_s_d = blink_en;
      dp_s_d    = dp_en;
    end

    if (scan_cnt_q >= SCAN_W'(BLANK_TIME)) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = visible ? dec_seg : SEG_BLANK;
      dp_d  = (dp_s_q[idx_q] && visible) ? DP_ON : DP_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      val_s_q       <= '0;
      en_s_q        <= '0;
      blink_s_q     <= '0;
      dp_s_q        <= '0;
      an_q          <= {DIGITS{AN_OFF}};
      seg_q         <= SEG_BLANK;
      dp_q          <= DP_OFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      val_s_q       <= val_s_d;
      en_s_q        <= en_s_d;
      blink_s_q     <= blink_s_d;
      dp_s_q        <= dp_s_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 4-digit, 4-cycle-slot, 16-cycle-blink setup.
module tb_seg_scan_driver;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned SCAN_TIME  = 4;
  localparam int unsigned BLANK_TIME = 1;
  localparam int unsigned BLINK_TIME = 16;

  logic                clk;
  logic                rst_n;
  logic [4*DIGITS-1:0] digit_val;
  logic [DIGITS-1:0]   digit_en;
  logic [DIGITS-1:0]   blink_en;
  logic [DIGITS-1:0]   dp_en;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;

  int n_run;
  int n_fail;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] an_tbl [4]   = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg_scan_driver #(
    .DIGITS     (DIGITS),
    .SCAN_TIME  (SCAN_TIME),
    .BLANK_TIME (BLANK_TIME),
    .BLINK_TIME (BLINK_TIME)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_val (digit_val),
    .digit_en  (digit_en),
    .blink_en  (blink_en),
    .dp_en     (dp_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    check({tag, " an"},  32'(an),  32'hF);
    check({tag, " seg"}, 32'(seg), 32'h7F);
    check({tag, " dp"},  32'(dp),  32'h1);
  endtask

  // One 16-cycle frame starting at the snapshot edge; segs = {s3,s2,s1,s0}, dps = dp level per slot.
  // digit_val is replaced with new_val right after sampling frame edge chg_edge (0 = never).
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps,
                             input int chg_edge, input logic [15:0] new_val);
    for (int e = 1; e <= 16; e++) begin
      int slot;
      int pos;
      tick();
      slot = (e - 1) / 4;
      pos  = (e - 1) % 4;
      if (pos == 0) begin
        check_dark($sformatf("%s e%0d blank", tag, e));
      end else begin
        check($sformatf("%s e%0d an", tag, e),  32'(an),  32'(an_tbl[slot]));
        check($sformatf("%s e%0d seg", tag, e), 32'(seg), 32'(segs[slot*7 +: 7]));
        check($sformatf("%s e%0d dp", tag, e),  32'(dp),  32'(dps[slot]));
      end
      if (e == chg_edge) digit_val = new_val;
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;

    // Reset held with random inputs
    rst_n     = 1'b0;
    digit_val = 16'($urandom);
    digit_en  = 4'($urandom);
    blink_en  = 4'($urandom);
    dp_en     = 4'($urandom);
    repeat (3) tick();
    check_dark("reset_hold");

    // Scan order
    digit_val = 16'h8421;
    digit_en  = 4'hF;
    blink_en  = 4'h0;
    dp_en     = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("scan0", {7'h00, 7'h19, 7'h24, 7'h79}, 4'hF, 0, 16'h0);
    check_frame("scan1", {7'h00, 7'h19, 7'h24, 7'h79}, 4'hF, 0, 16'h0);

    // Snapshot: change while digit 2 is shown, visible only next frame
    check_frame("snap_old", {7'h00, 7'h19, 7'h24, 7'h79}, 4'hF, 10, 16'h3A5C);
    check_frame("snap_new", {7'h30, 7'h08, 7'h12, 7'h46}, 4'hF, 0, 16'h0);

    // Reset asserted mid-slot goes dark without a clock edge
    tick();
    tick();
    check("pre_rst an",  32'(an),  32'hE);
    check("pre_rst seg", 32'(seg), 32'h46);
    rst_n = 1'b0;
    #1;
    check_dark("async_rst");

    // Enable mask, then decimal point on digit 0
    digit_val = 16'h8421;
    digit_en  = 4'b1010;
    dp_en     = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("en_mask", {7'h00, 7'h7F, 7'h24, 7'h7F}, 4'hF, 0, 16'h0);
    digit_en = 4'hF;
    check_frame("dp0", {7'h00, 7'h19, 7'h24, 7'h79}, 4'b1110, 0, 16'h0);

    // Blink on digit 0 from a fresh reset so blink phase aligns with frames
    rst_n = 1'b0;
    #1;
    digit_val = 16'h0000;
    digit_en  = 4'hF;
    blink_en  = 4'b0001;
    dp_en     = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("blink_on0",  {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 0, 16'h0);
    check_frame("blink_off0", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'hF, 0, 16'h0);
    check_frame("blink_on1",  {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 0, 16'h0);
    check_frame("blink_off1", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'hF, 0, 16'h0);

    // Full decode sweep on digit 0
    blink_en = 4'h0;
    for (int v = 0; v < 16; v++) begin
      digit_val = {12'h000, 4'(v)};
      check_frame($sformatf("dec%0h", v), {7'h40, 7'h40, 7'h40, hex_tbl[v]}, 4'hF, 0, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
